// File: rtl/pair_pkg.sv
// Shared types for the pair unpacker: packed word layout and emit FSM states.
// A packed word carries two nibble fields, b in the upper half and a in the lower half.
package pair_pkg;

    localparam int NIB_W = 4;

    typedef struct packed {
        logic [NIB_W-1:0] b;
        logic [NIB_W-1:0] a;
    } pair_t;

    typedef enum logic {
        EMIT_A = 1'b0,
        EMIT_B = 1'b1
    } emit_state_e;

endpackage

// File: rtl/pair_fifo.sv
// DEPTH-entry FIFO of packed words; head is readable the cycle after a push into empty.
// Pushes when full and pops when empty are ignored; full/empty come straight from flops.
module pair_fifo
    import pair_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  logic  pop,
    input  pair_t din,
    output pair_t dout,
    output logic  full,
    output logic  empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    pair_t          mem_q [DEPTH];
    pair_t          mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           do_push;
    logic           do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/pair_unpacker.sv
// Splits each buffered 8-bit word into field a then field b, one nibble per output transfer.
// Word visible one cycle after acceptance; in_ready drops when the FIFO is full, never bypassed.
module pair_unpacker
    import pair_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*NIB_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NIB_W-1:0]   out_nib,
    output logic               out_sel,
    output logic [7:0]         words_done
);

    pair_t             in_word;
    pair_t             head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              out_xfer;
    logic [NIB_W-1:0]  live_nib;
    logic              live_sel;

    emit_state_e       state_q, state_d;
    logic [7:0]        words_done_q, words_done_d;
    logic [NIB_W-1:0]  held_nib_q, held_nib_d;
    logic              held_sel_q, held_sel_d;
    logic              rdy_q, rdy_d;

    assign in_word   = pair_t'(in_data);
    assign in_ready  = rdy_q && !fifo_full;
    assign out_valid = !fifo_empty;
    assign push      = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign pop       = out_xfer && (state_q == EMIT_B);

    assign live_sel  = (state_q == EMIT_B);
    assign live_nib  = live_sel ? head.b : head.a;

    // While empty the outputs replay the last presented field rather than a stale slot.
    assign out_nib    = out_valid ? live_nib : held_nib_q;
    assign out_sel    = out_valid ? live_sel : held_sel_q;
    assign words_done = words_done_q;

    pair_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (in_word),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        words_done_d = words_done_q;
        held_nib_d   = held_nib_q;
        held_sel_d   = held_sel_q;
        rdy_d        = 1'b1;
        if (out_valid) begin
            held_nib_d = live_nib;
            held_sel_d = live_sel;
        end
        if (out_xfer) begin
            state_d = (state_q == EMIT_A) ? EMIT_B : EMIT_A;
        end
        if (pop) begin
            words_done_d = words_done_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= EMIT_A;
            words_done_q <= '0;
            held_nib_q   <= '0;
            held_sel_q   <= 1'b0;
            rdy_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            words_done_q <= words_done_d;
            held_nib_q   <= held_nib_d;
            held_sel_q   <= held_sel_d;
            rdy_q        <= rdy_d;
        end
    end

endmodule

// File: tb/tb_pair_unpacker.sv
// Self-checking bench for pair_unpacker: vector table, scoreboard queue and corner sequences.
`timescale 1ns/1ps
module tb_pair_unpacker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_nib;
    logic       out_sel;
    logic [7:0] words_done;

    always #5 clk = ~clk;

    pair_unpacker #(
        .DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_nib    (out_nib),
        .out_sel    (out_sel),
        .words_done (words_done)
    );

    typedef struct packed {
        logic [3:0] nib;
        logic       sel;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic [3:0] ea;
        logic [3:0] eb;
    } vec_t;

    int         n_chk = 0;
    int         n_err = 0;
    exp_t       sb[$];
    exp_t       e;
    logic [3:0] exp_a;
    logic [3:0] exp_b;
    vec_t       vecs[6];
    logic [7:0] wd0;
    logic [7:0] rnd;
    int         gaps;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input int val);
        n_chk++;
        n_err++;
        $display("FAIL %s: got %0d, want completion", name, val);
    endtask

    // Scoreboard: accepted words queue their two fields, every output transfer pops one.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (in_valid && in_ready) begin
                sb.push_back({exp_a, 1'b0});
                sb.push_back({exp_b, 1'b1});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_out", int'(out_nib));
                end else begin
                    e = sb.pop_front();
                    chk("sb_nib", 32'(out_nib), 32'(e.nib));
                    chk("sb_sel", 32'(out_sel), 32'(e.sel));
                end
            end
        end
    end

    task automatic send_word(input logic [7:0] d, input logic [3:0] ea, input logic [3:0] eb);
        bit ok = 1'b0;
        in_data  = d;
        exp_a    = ea;
        exp_b    = eb;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("send_timeout", int'(d));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("drain_timeout", sb.size());
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got time %0t, want finish", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        exp_a     = 4'h0;
        exp_b     = 4'h0;

        vecs[0] = '{8'hB5, 4'h5, 4'hB};
        vecs[1] = '{8'h00, 4'h0, 4'h0};
        vecs[2] = '{8'hFF, 4'hF, 4'hF};
        vecs[3] = '{8'h3C, 4'hC, 4'h3};
        vecs[4] = '{8'hA0, 4'h0, 4'hA};
        vecs[5] = '{8'h0E, 4'hE, 4'h0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_words_done", 32'(words_done), 32'd0);
        chk("rst_out_nib", 32'(out_nib), 32'd0);
        chk("rst_out_sel", 32'(out_sel), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("in_ready_before_edge", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("in_ready_after_edge", 32'(in_ready), 32'd1);

        // Single word 0xB5 with out_ready held high
        out_ready = 1'b1;
        in_data   = 8'hB5;
        exp_a     = 4'h5;
        exp_b     = 4'hB;
        in_valid  = 1'b1;
        @(negedge clk);
        chk("no_same_cycle_out", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("b5_valid_a", 32'(out_valid), 32'd1);
        chk("b5_nib_a", 32'(out_nib), 32'h5);
        chk("b5_sel_a", 32'(out_sel), 32'd0);
        chk("b5_done_before", 32'(words_done), 32'd0);
        @(negedge clk);
        chk("b5_nib_b", 32'(out_nib), 32'hB);
        chk("b5_sel_b", 32'(out_sel), 32'd1);
        @(posedge clk);
        #1;
        chk("b5_done_after", 32'(words_done), 32'd1);
        chk("b5_empty", 32'(out_valid), 32'd0);
        chk("empty_hold_nib", 32'(out_nib), 32'hB);
        chk("empty_hold_sel", 32'(out_sel), 32'd1);

        // Vector table
        for (int v = 0; v < 6; v++) begin
            wd0 = words_done;
            send_word(vecs[v].data, vecs[v].ea, vecs[v].eb);
            drain();
            chk("vec_words_done", 32'(words_done), 32'(wd0 + 8'd1));
        end

        // Backpressure: two words fill the FIFO, the third stalls
        out_ready = 1'b0;
        send_word(8'h21, 4'h1, 4'h2);
        send_word(8'h43, 4'h3, 4'h4);
        in_data  = 8'h65;
        exp_a    = 4'h5;
        exp_b    = 4'h6;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            chk("bp_hold_nib", 32'(out_nib), 32'h1);
            chk("bp_hold_sel", 32'(out_sel), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_full_a", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("bp_no_bypass", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("bp_accept_after_pop", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // Stall in EMIT_B showing 0xB
        out_ready = 1'b0;
        send_word(8'hB5, 4'h5, 4'hB);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_nib", 32'(out_nib), 32'hB);
            chk("stall_sel", 32'(out_sel), 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Streaming 10 words: one nibble per cycle
        wd0       = words_done;
        gaps      = 0;
        out_ready = 1'b1;
        fork
            begin
                for (int w = 0; w < 10; w++) begin
                    rnd = 8'($urandom_range(0, 255));
                    send_word(rnd, rnd[3:0], rnd[7:4]);
                end
            end
            begin
                bit seen = 1'b0;
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                if (!seen) fail_now("stream_start_timeout", 0);
                for (int k = 0; k < 20; k++) begin
                    if (!(out_valid && out_ready)) gaps++;
                    @(negedge clk);
                end
            end
        join
        drain();
        chk("stream_gaps", 32'(gaps), 32'd0);
        chk("stream_words_done", 32'(words_done), 32'(wd0 + 8'd10));

        // Wrap: 257 words from reset
        do_reset();
        out_ready = 1'b1;
        for (int w = 0; w < 257; w++) begin
            rnd = 8'($urandom_range(0, 255));
            send_word(rnd, rnd[3:0], rnd[7:4]);
        end
        drain();
        chk("wrap_words_done", 32'(words_done), 32'd1);

        // Reset mid-word with two words buffered
        out_ready = 1'b0;
        send_word(8'h12, 4'h2, 4'h1);
        send_word(8'h34, 4'h4, 4'h3);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("mid_in_emit_b", 32'(out_sel), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_words_done", 32'(words_done), 32'd0);
        sb.delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_word(8'h7C, 4'hC, 4'h7);
        drain();
        chk("mid_after_words_done", 32'(words_done), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
